// File: rtl/tri_edge_sequencer_pkg.sv
// Shared types and constants for the triangle edge sequencer.
package tri_edge_sequencer_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW,
        RELEASE
    } state_e;

    localparam logic [1:0] EDGE_01 = 2'd0;
    localparam logic [1:0] EDGE_12 = 2'd1;
    localparam logic [1:0] EDGE_20 = 2'd2;

endpackage

// File: rtl/tri_edge_sequencer_fifo.sv
// Small input queue for whole triangles; flush wins over a same-cycle push.
module tri_fifo #(
    parameter int WIDTH = 60,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/tri_edge_sequencer.sv
// Feeds each queued triangle's edges to a line engine one at a time, with a per-edge watchdog.
module tri_edge_sequencer #(
    parameter int COORD_W = tri_edge_sequencer_pkg::COORD_W,
    parameter int CLOSED  = 1,
    parameter int TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               abort,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] tri_x0,
    input  logic [COORD_W-1:0] tri_y0,
    input  logic [COORD_W-1:0] tri_x1,
    input  logic [COORD_W-1:0] tri_y1,
    input  logic [COORD_W-1:0] tri_x2,
    input  logic [COORD_W-1:0] tri_y2,
    output logic               line_enable,
    output logic [COORD_W-1:0] line_x0,
    output logic [COORD_W-1:0] line_y0,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    input  logic               line_done,
    output logic [1:0]         edge_idx,
    output logic               busy,
    output logic               tri_done,
    output logic               timeout_err
);

    import tri_edge_sequencer_pkg::*;

    localparam int         VW        = 6 * COORD_W;
    localparam int         LW        = 4 * COORD_W;
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST_EDGE = (CLOSED != 0) ? EDGE_20 : EDGE_12;

    state_e            state_q, state_d;
    logic [1:0]        edge_q, edge_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]     vert_q, vert_d;
    logic [LW-1:0]     line_q, line_d;
    logic              err_q, err_d;
    logic              pop;
    logic [VW-1:0]     fifo_rdata;
    logic              fifo_full, fifo_empty;

    function automatic logic [LW-1:0] edge_ends(input logic [VW-1:0] v, input logic [1:0] e);
        logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
        {x0, y0, x1, y1, x2, y2} = v;
        case (e)
            EDGE_01: return {x0, y0, x1, y1};
            EDGE_12: return {x1, y1, x2, y2};
            default: return {x2, y2, x0, y0};
        endcase
    endfunction

    tri_fifo #(
        .WIDTH (VW),
        .DEPTH (2)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (abort),
        .push   (tri_valid),
        .pop    (pop),
        .wdata  ({tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2}),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            edge_q  <= EDGE_01;
            cnt_q   <= '0;
            vert_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            vert_q  <= vert_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    // Endpoints are loaded on entry to SETUP so they are already stable when DRAW raises enable.
    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        cnt_d   = cnt_q;
        vert_d  = vert_q;
        line_d  = line_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    vert_d  = fifo_rdata;
                    edge_d  = EDGE_01;
                    line_d  = edge_ends(fifo_rdata, EDGE_01);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                cnt_d = cnt_q + 1'b1;
                if (line_done) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = '0;
                if (edge_q == LAST_EDGE) begin
                    edge_d  = EDGE_01;
                    state_d = IDLE;
                end else begin
                    edge_d  = edge_q + 2'd1;
                    line_d  = edge_ends(vert_q, edge_q + 2'd1);
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            edge_d  = EDGE_01;
            cnt_d   = '0;
            pop     = 1'b0;
        end
    end

    assign tri_ready   = !fifo_full;
    assign line_enable = (state_q == DRAW);
    assign busy        = (state_q != IDLE);
    assign tri_done    = (state_q == RELEASE) && (edge_q == LAST_EDGE) && !abort;
    assign timeout_err = err_q;
    assign edge_idx    = edge_q;
    assign {line_x0, line_y0, line_x1, line_y1} = line_q;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Directed bench: closed-triangle instance (a) and open-polyline instance (b) on shared stimulus.
module tb_tri_edge_sequencer;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         resetn, abort, tri_valid, line_done;
    logic [W-1:0] tx0, ty0, tx1, ty1, tx2, ty2;

    logic         rdy_a, en_a, busy_a, done_a, err_a;
    logic [1:0]   eidx_a;
    logic [W-1:0] lx0_a, ly0_a, lx1_a, ly1_a;
    logic         rdy_b, en_b, busy_b, done_b, err_b;
    logic [1:0]   eidx_b;
    logic [W-1:0] lx0_b, ly0_b, lx1_b, ly1_b;

    bit           sel = 1'b0;
    logic         rdy_o, en_o, busy_o, done_o, err_o;
    logic [1:0]   eidx_o;
    logic [W-1:0] lx0_o, ly0_o, lx1_o, ly1_o;

    int checks = 0;
    int errors = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;

    always #5 clk = ~clk;

    tri_edge_sequencer #(.COORD_W(W), .CLOSED(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .resetn(resetn), .abort(abort), .tri_valid(tri_valid), .tri_ready(rdy_a),
        .tri_x0(tx0), .tri_y0(ty0), .tri_x1(tx1), .tri_y1(ty1), .tri_x2(tx2), .tri_y2(ty2),
        .line_enable(en_a), .line_x0(lx0_a), .line_y0(ly0_a), .line_x1(lx1_a), .line_y1(ly1_a),
        .line_done(line_done), .edge_idx(eidx_a), .busy(busy_a), .tri_done(done_a),
        .timeout_err(err_a)
    );

    tri_edge_sequencer #(.COORD_W(W), .CLOSED(0), .TIMEOUT(16)) dut_b (
        .clk(clk), .resetn(resetn), .abort(abort), .tri_valid(tri_valid), .tri_ready(rdy_b),
        .tri_x0(tx0), .tri_y0(ty0), .tri_x1(tx1), .tri_y1(ty1), .tri_x2(tx2), .tri_y2(ty2),
        .line_enable(en_b), .line_x0(lx0_b), .line_y0(ly0_b), .line_x1(lx1_b), .line_y1(ly1_b),
        .line_done(line_done), .edge_idx(eidx_b), .busy(busy_b), .tri_done(done_b),
        .timeout_err(err_b)
    );

    always_comb begin
        rdy_o  = sel ? rdy_b  : rdy_a;
        en_o   = sel ? en_b   : en_a;
        busy_o = sel ? busy_b : busy_a;
        done_o = sel ? done_b : done_a;
        err_o  = sel ? err_b  : err_a;
        eidx_o = sel ? eidx_b : eidx_a;
        lx0_o  = sel ? lx0_b  : lx0_a;
        ly0_o  = sel ? ly0_b  : ly0_a;
        lx1_o  = sel ? lx1_b  : lx1_a;
        ly1_o  = sel ? ly1_b  : ly1_a;
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) dcnt_a++;
        if (done_b === 1'b1) dcnt_b++;
    end

    task automatic do_reset;
        resetn    = 1'b0;
        abort     = 1'b0;
        tri_valid = 1'b0;
        line_done = 1'b0;
        {tx0, ty0, tx1, ty1, tx2, ty2} = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        int n = 0;
        tx0 = W'(x0); ty0 = W'(y0); tx1 = W'(x1); ty1 = W'(y1); tx2 = W'(x2); ty2 = W'(y2);
        tri_valid = 1'b1;
        while (rdy_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: tri_ready=%b, expected 1", rdy_o);
        end
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    task automatic serve_edge(input logic [1:0] idx, input int x0, input int y0,
                              input int x1, input int y1, input int dly, input logic last);
        int n = 0;
        logic [4*W-1:0] exp_l;
        exp_l = {W'(x0), W'(y0), W'(x1), W'(y1)};
        while (en_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (en_o !== 1'b1) begin
            errors++;
            $display("FAIL edge_start[%0d]: line_enable=%b, expected 1", idx, en_o);
            return;
        end
        checks++;
        if (eidx_o !== idx || {lx0_o, ly0_o, lx1_o, ly1_o} !== exp_l) begin
            errors++;
            $display("FAIL edge_ends: got idx=%0d (%0d,%0d)-(%0d,%0d), expected idx=%0d (%0d,%0d)-(%0d,%0d)",
                     eidx_o, $signed(lx0_o), $signed(ly0_o), $signed(lx1_o), $signed(ly1_o),
                     idx, x0, y0, x1, y1);
        end
        repeat (dly) @(negedge clk);
        checks++;
        if (en_o !== 1'b1 || {lx0_o, ly0_o, lx1_o, ly1_o} !== exp_l) begin
            errors++;
            $display("FAIL edge_hold[%0d]: enable=%b ends=%h, expected enable=1 ends=%h",
                     idx, en_o, {lx0_o, ly0_o, lx1_o, ly1_o}, exp_l);
        end
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        checks++;
        if (en_o !== 1'b0 || done_o !== last) begin
            errors++;
            $display("FAIL edge_release[%0d]: enable=%b tri_done=%b, expected enable=0 tri_done=%b",
                     idx, en_o, done_o, last);
        end
    endtask

    task automatic test_reset;
        sel = 1'b0;
        do_reset();
        checks++;
        if ({rdy_o, en_o, busy_o, done_o, err_o, eidx_o} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/en/busy/done/err/idx=%b, expected 1000000",
                     {rdy_o, en_o, busy_o, done_o, err_o, eidx_o});
        end
        checks++;
        if ({lx0_o, ly0_o, lx1_o, ly1_o} !== '0) begin
            errors++;
            $display("FAIL reset_line: line=%h, expected 0", {lx0_o, ly0_o, lx1_o, ly1_o});
        end
    endtask

    task automatic test_single;
        int d0;
        sel = 1'b0;
        do_reset();
        d0 = dcnt_a;
        push_tri(10, 10, 50, 10, 30, 40);
        serve_edge(2'd0, 10, 10, 50, 10, 5, 1'b0);
        serve_edge(2'd1, 50, 10, 30, 40, 5, 1'b0);
        serve_edge(2'd2, 30, 40, 10, 10, 5, 1'b1);
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dcnt_a - d0 != 1) begin
            errors++;
            $display("FAIL single_end: busy=%b tri_done pulses=%0d, expected busy=0 pulses=1",
                     busy_o, dcnt_a - d0);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        sel = 1'b0;
        do_reset();
        d0 = dcnt_a;
        fork
            begin
                push_tri(1, 2, 3, 4, 5, 6);
                push_tri(100, -100, -200, 200, 7, 8);
                push_tri(-512, 511, 0, 0, 511, -512);
                checks++;
                if (rdy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full: tri_ready=%b, expected 0", rdy_o);
                end
            end
            begin
                serve_edge(2'd0, 1, 2, 3, 4, 1, 1'b0);
                serve_edge(2'd1, 3, 4, 5, 6, 3, 1'b0);
                serve_edge(2'd2, 5, 6, 1, 2, 0, 1'b1);
                serve_edge(2'd0, 100, -100, -200, 200, 2, 1'b0);
                serve_edge(2'd1, -200, 200, 7, 8, 0, 1'b0);
                serve_edge(2'd2, 7, 8, 100, -100, 4, 1'b1);
                serve_edge(2'd0, -512, 511, 0, 0, 1, 1'b0);
                serve_edge(2'd1, 0, 0, 511, -512, 1, 1'b0);
                serve_edge(2'd2, 511, -512, -512, 511, 1, 1'b1);
            end
        join
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dcnt_a - d0 != 3) begin
            errors++;
            $display("FAIL b2b_end: busy=%b tri_done pulses=%0d, expected busy=0 pulses=3",
                     busy_o, dcnt_a - d0);
        end
    endtask

    task automatic test_open;
        int  d0;
        bit  seen = 1'b0;
        sel = 1'b1;
        do_reset();
        d0 = dcnt_b;
        push_tri(0, 0, 5, 5, 9, 0);
        serve_edge(2'd0, 0, 0, 5, 5, 2, 1'b0);
        serve_edge(2'd1, 5, 5, 9, 0, 2, 1'b1);
        repeat (20) begin
            @(negedge clk);
            if (en_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || busy_o !== 1'b0 || dcnt_b - d0 != 1) begin
            errors++;
            $display("FAIL open_end: extra_edge=%b busy=%b pulses=%0d, expected 0 0 1",
                     seen, busy_o, dcnt_b - d0);
        end
        sel = 1'b0;
    endtask

    task automatic test_timeout;
        int d0;
        int n;
        sel = 1'b0;
        do_reset();
        d0 = dcnt_a;
        push_tri(1, 1, 2, 2, 3, 3);
        for (int e = 0; e < 3; e++) begin
            n = 0;
            while (en_o !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (en_o === 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 16 || err_o !== 1'b1 || done_o !== (e == 2)) begin
                errors++;
                $display("FAIL timeout_edge[%0d]: draw_cycles=%0d err=%b tri_done=%b, expected 16 1 %0d",
                         e, n, err_o, done_o, (e == 2));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || dcnt_a - d0 != 1) begin
            errors++;
            $display("FAIL timeout_end: err=%b busy=%b pulses=%0d, expected 1 0 1",
                     err_o, busy_o, dcnt_a - d0);
        end
    endtask

    task automatic test_abort;
        int d0;
        int n = 0;
        bit seen = 1'b0;
        sel = 1'b0;
        do_reset();
        d0 = dcnt_a;
        push_tri(10, 20, 30, 40, 50, 60);
        push_tri(1, 1, 1, 1, 1, 1);
        serve_edge(2'd0, 10, 20, 30, 40, 3, 1'b0);
        while (en_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (en_o !== 1'b1 || eidx_o !== 2'd1) begin
            errors++;
            $display("FAIL abort_pre: enable=%b idx=%0d, expected 1 1", en_o, eidx_o);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy_o, en_o, rdy_o, eidx_o, err_o} !== 6'b001000) begin
            errors++;
            $display("FAIL abort_state: busy/en/rdy/idx/err=%b, expected 001000",
                     {busy_o, en_o, rdy_o, eidx_o, err_o});
        end
        repeat (30) begin
            @(negedge clk);
            if (en_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || dcnt_a != d0) begin
            errors++;
            $display("FAIL abort_quiet: extra_edge=%b pulses=%0d, expected 0 0", seen, dcnt_a - d0);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        sel = 1'b0;
        do_reset();
        push_tri(1, 2, 3, 4, 5, 6);
        while (en_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({rdy_o, en_o, busy_o, done_o, err_o, eidx_o} !== 7'b1000000 ||
            {lx0_o, ly0_o, lx1_o, ly1_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: rdy/en/busy/done/err/idx=%b line=%h, expected 1000000 and 0",
                     {rdy_o, en_o, busy_o, done_o, err_o, eidx_o}, {lx0_o, ly0_o, lx1_o, ly1_o});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        push_tri(-3, 7, 4, -2, 4, -2);
        serve_edge(2'd0, -3, 7, 4, -2, 2, 1'b0);
        serve_edge(2'd1, 4, -2, 4, -2, 2, 1'b0);
        serve_edge(2'd2, 4, -2, -3, 7, 2, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_open();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_edge_sequencer.md
TRI_EDGE_SEQUENCER -- requirements
Module: tri_edge_sequencer

Interface
REQ-001 Parameter COORD_W, default 10; signed two's-complement coordinate width, matching the line engine.
REQ-002 Parameter CLOSED, default 1; 1 = three edges (v0-v1, v1-v2, v2-v0), 0 = two edges (v0-v1, v1-v2).
REQ-003 Parameter TIMEOUT, default 2048; max DRAW cycles per edge before forced advance.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 abort  in  1  synchronous flush request.
REQ-007 tri_valid  in  1  triangle offered; tri_ready  out  1  triangle accepted when both high.
REQ-008 tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2  in  COORD_W each  triangle vertices.
REQ-009 line_enable  out  1  level enable to line engine.
REQ-010 line_x0, line_y0, line_x1, line_y1  out  COORD_W each  current edge endpoints.
REQ-011 line_done  in  1  engine finished current edge (level).
REQ-012 edge_idx  out  2  current edge number 0..2.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 tri_done  out  1  one-cycle pulse, triangle's last edge released.
REQ-015 timeout_err  out  1  sticky, set when any edge times out.

Function
REQ-016 Input buffer SHALL be a 2-entry FIFO; tri_ready = not full; push when tri_valid and tri_ready.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged; a push into empty FIFO SHALL NOT be popped in the same cycle.
REQ-018 States: IDLE, SETUP, DRAW, RELEASE.
REQ-019 IDLE: if FIFO non-empty, pop into working vertex registers, edge_idx=0 -> SETUP; else stay.
REQ-020 SETUP (1 cycle): line_enable=0, line_* driven with edge_idx endpoints -> DRAW.
REQ-021 DRAW: line_enable=1, line_* held constant; timeout counter increments each cycle; on line_done=1 -> RELEASE.
REQ-022 DRAW: counter reaching TIMEOUT-1 without line_done SHALL set timeout_err and -> RELEASE.
REQ-023 RELEASE (1 cycle): line_enable=0, counter cleared; if edge_idx is last (2 if CLOSED else 1) pulse tri_done, edge_idx=0 -> IDLE; else edge_idx+1 -> SETUP.
REQ-024 line_enable SHALL be low for at least one cycle between consecutive edges so the engine re-arms.
REQ-025 Edge endpoints: edge 0 = (v0,v1), edge 1 = (v1,v2), edge 2 = (v2,v0); coordinates passed unmodified.
REQ-026 Zero-length edges SHALL be issued normally (no skip).
REQ-027 abort SHALL, next cycle, empty FIFO, force IDLE, line_enable=0, edge_idx=0, counter=0; tri_done not pulsed; timeout_err unaffected; abort overrides a same-cycle push.
REQ-028 line_done outside DRAW SHALL be ignored.

Reset
REQ-029 resetn low SHALL asynchronously set: state IDLE, FIFO empty (tri_ready=1), line_enable=0, line_* =0, edge_idx=0, busy=0, tri_done=0, timeout_err=0, counter=0.
REQ-030 Reset mid-DRAW SHALL drop line_enable immediately; pending triangles are lost.

Structure
REQ-031 Shared package holds COORD_W, state enumeration, edge index constants (EDGE_01, EDGE_12, EDGE_20).
REQ-032 FIFO SHALL be sub-module tri_fifo (parameterised width 6*COORD_W, depth 2).

Verification
REQ-033 Single triangle (10,10),(50,10),(30,40), line_done 5 cycles after each enable -> three edges in order, enable low one cycle between, one tri_done, busy falls after.
REQ-034 Three back-to-back triangles with tri_valid held -> tri_ready low while FIFO full, all 9 edges issued in order, three tri_done pulses.
REQ-035 CLOSED=0, triangle (0,0),(5,5),(9,0) -> only edges 0 and 1, tri_done after edge 1.
REQ-036 line_done never asserted, TIMEOUT=16 -> each edge leaves DRAW after 16 cycles, timeout_err set and stays set, tri_done still pulses.
REQ-037 abort during DRAW of edge 1 with one triangle queued -> next cycle IDLE, line_enable=0, tri_ready=1, no tri_done, no further edges.
REQ-038 resetn low during DRAW -> all outputs to reset values asynchronously; negative coordinate (-3,7) passes through unchanged after restart.
